cmos_rgb565_capture: RTL and testbench

- Camera-side capture stage driven by the OV5640 byte stream: cmos_db, cmos_href, cmos_vsync, all in the cmos_pclk domain.
- Waits for sensor configuration to complete, then discards a number of warm-up frames.
- Pairs bytes into RGB565 pixels and tags each pixel with x/y coordinates and start-of-frame, end-of-line and end-of-frame markers.
- Output feeds the downstream frame buffer write / CDC FIFO stage. It also provides frame counting and per-frame geometry error reporting for PMOD/UART debug.

---
 rtl/cmos_rgb565_capture.sv | 177 +++++++++++++++++
 tb/tb_cmos_rgb565_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_capture.sv
// OV5640 byte-stream capture: waits for sensor config, drops warm-up frames, then pairs
// bytes into RGB565 pixels tagged with x/y, sof/eol/eof and per-frame geometry errors.
`timescale 1ns/1ps
module cmos_rgb565_capture #(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        cmos_pclk,
  input  logic        I_rst_n,
  input  logic        I_cfg_done,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [7:0]  I_data,
  output logic        O_pix_valid,
  output logic [15:0] O_pix_data,
  output logic [11:0] O_pix_x,
  output logic [11:0] O_pix_y,
  output logic        O_sof,
  output logic        O_eol,
  output logic        O_eof,
  output logic [15:0] O_frame_cnt,
  output logic        O_frame_err,
  output logic        O_capture_active,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  localparam logic [11:0] X_END    = 12'(H_RES);
  localparam logic [11:0] X_LAST   = 12'(H_RES - 1);
  localparam logic [11:0] Y_END    = 12'(V_RES);
  localparam logic [7:0]  SKIP_MAX = 8'(SKIP_FRAMES);

  state_t      state;
  logic        vsync_d1, vsync_d2;
  logic        href_d1, href_d2;
  logic [7:0]  data_d1;
  logic [7:0]  skip_cnt;
  logic [11:0] x, y;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        line_seen;
  logic        err_acc;

  logic vs_rise, byte_ok, href_fall, x_full, y_full;

  assign vs_rise   = vsync_d1 & ~vsync_d2;
  // Bytes seen while vsync is high belong to no frame and are silently ignored.
  assign byte_ok   = href_d1 & ~vsync_d1;
  assign href_fall = href_d2 & ~href_d1;
  assign x_full    = (x == X_END);
  assign y_full    = (y == Y_END);
  assign dbg_state = state;

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vsync_d1 <= 1'b0;
      vsync_d2 <= 1'b0;
      href_d1  <= 1'b0;
      href_d2  <= 1'b0;
      data_d1  <= 8'd0;
    end else begin
      vsync_d1 <= I_vsync;
      vsync_d2 <= vsync_d1;
      href_d1  <= I_href;
      href_d2  <= href_d1;
      data_d1  <= I_data;
    end
  end

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state            <= WAIT_CFG;
      skip_cnt         <= 8'd0;
      x                <= 12'd0;
      y                <= 12'd0;
      phase            <= 1'b0;
      hi_byte          <= 8'd0;
      line_seen        <= 1'b0;
      err_acc          <= 1'b0;
      O_pix_valid      <= 1'b0;
      O_pix_data       <= 16'd0;
      O_pix_x          <= 12'd0;
      O_pix_y          <= 12'd0;
      O_sof            <= 1'b0;
      O_eol            <= 1'b0;
      O_eof            <= 1'b0;
      O_frame_cnt      <= 16'd0;
      O_frame_err      <= 1'b0;
      O_capture_active <= 1'b0;
    end else begin
      O_pix_valid <= 1'b0;
      O_sof       <= 1'b0;
      O_eol       <= 1'b0;
      O_eof       <= 1'b0;
      if (!I_cfg_done) begin
        state            <= WAIT_CFG;
        O_capture_active <= 1'b0;
      end else begin
        case (state)
          WAIT_CFG: begin
            state    <= SKIP;
            skip_cnt <= 8'd0;
          end
          SKIP: begin
            if (vs_rise) begin
              if (skip_cnt == SKIP_MAX) begin
                state            <= CAPTURE;
                O_capture_active <= 1'b1;
                x                <= 12'd0;
                y                <= 12'd0;
                phase            <= 1'b0;
                line_seen        <= 1'b0;
                // Discard errors left over from a capture aborted by a config drop.
                err_acc          <= 1'b0;
              end else begin
                skip_cnt <= skip_cnt + 8'd1;
              end
            end
          end
          CAPTURE: begin
            if (vs_rise) begin
              O_eof       <= 1'b1;
              O_frame_cnt <= O_frame_cnt + 16'd1;
              O_frame_err <= err_acc | ~y_full;
              err_acc     <= 1'b0;
              x           <= 12'd0;
              y           <= 12'd0;
              phase       <= 1'b0;
              line_seen   <= 1'b0;
            end else if (byte_ok) begin
              line_seen <= 1'b1;
              if (y_full) begin
                err_acc <= 1'b1;
              end else if (!phase) begin
                hi_byte <= data_d1;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                // x parks at H_RES so every overflow pixel is dropped, not wrapped.
                if (x_full) begin
                  err_acc <= 1'b1;
                end else begin
                  O_pix_valid <= 1'b1;
                  O_pix_data  <= {hi_byte, data_d1};
                  O_pix_x     <= x;
                  O_pix_y     <= y;
                  O_sof       <= (x == 12'd0) && (y == 12'd0);
                  O_eol       <= (x == X_LAST);
                  x           <= x + 12'd1;
                end
              end
            end else if (href_fall) begin
              if (line_seen) begin
                if (phase || !x_full) err_acc <= 1'b1;
                if (x != 12'd0) y <= y + 12'd1;
              end
              x         <= 12'd0;
              phase     <= 1'b0;
              line_seen <= 1'b0;
            end
          end
          default: begin
            state            <= WAIT_CFG;
            O_capture_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Bench for cmos_rgb565_capture: frame/line-level reference model with a per-cycle compare
// process, plus literal expectations for the skip, assembly, error and reset scenarios.
`timescale 1ns/1ps
module tb_cmos_rgb565_capture;
  localparam int H_RES       = 4;
  localparam int V_RES       = 2;
  localparam int SKIP_FRAMES = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        cmos_pclk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_cfg_done = 1'b0;
  logic        I_vsync = 1'b0;
  logic        I_href = 1'b0;
  logic [7:0]  I_data = 8'd0;
  logic        O_pix_valid;
  logic [15:0] O_pix_data;
  logic [11:0] O_pix_x;
  logic [11:0] O_pix_y;
  logic        O_sof;
  logic        O_eol;
  logic        O_eof;
  logic [15:0] O_frame_cnt;
  logic        O_frame_err;
  logic        O_capture_active;
  logic [1:0]  dbg_state;

  always #5 cmos_pclk = ~cmos_pclk;

  cmos_rgb565_capture #(
    .H_RES(H_RES), .V_RES(V_RES), .SKIP_FRAMES(SKIP_FRAMES)
  ) dut (
    .cmos_pclk(cmos_pclk), .I_rst_n(I_rst_n), .I_cfg_done(I_cfg_done),
    .I_vsync(I_vsync), .I_href(I_href), .I_data(I_data),
    .O_pix_valid(O_pix_valid), .O_pix_data(O_pix_data), .O_pix_x(O_pix_x),
    .O_pix_y(O_pix_y), .O_sof(O_sof), .O_eol(O_eol), .O_eof(O_eof),
    .O_frame_cnt(O_frame_cnt), .O_frame_err(O_frame_err),
    .O_capture_active(O_capture_active), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct { int cyc; logic [15:0] data; logic [11:0] x; logic [11:0] y; logic sof; logic eol; } pix_t;
  typedef struct { int cyc; logic [15:0] cnt; logic err; } eof_t;
  typedef struct { int cyc; logic act; } act_t;
  typedef enum { M_WAIT, M_SKIP, M_CAP } mode_t;

  pix_t  pix_q[$];
  pix_t  log_q[$];
  eof_t  eof_q[$];
  act_t  act_q[$];
  int    lo_put_q[$];
  pix_t  cp;
  eof_t  ce;
  act_t  ca;

  int    cyc = 0, put_cyc = 0, checks = 0, errors = 0;
  bit    chk_en = 1'b0;
  logic  cfg_lvl = 1'b0;
  logic  [15:0] exp_cnt = 16'd0;
  logic  exp_err = 1'b0, exp_act = 1'b0;
  logic  [7:0] line_buf [0:15];
  int    tmp_n, tmp_max;

  // reference model, tracked per line / per frame
  mode_t m_mode = M_WAIT;
  int    m_skips = 0, m_y = 0;
  logic  [15:0] m_cnt = 16'd0;
  logic  m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge cmos_pclk) begin
    if (chk_en && I_rst_n) begin
      while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
        chk("pix_missing_at_cycle", 32'(cyc), 32'(pix_q[0].cyc));
        void'(pix_q.pop_front());
      end
      if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
        cp = pix_q.pop_front();
        chk("pix_valid", 32'(O_pix_valid), 32'd1);
        chk("pix_data", 32'(O_pix_data), 32'(cp.data));
        chk("pix_x", 32'(O_pix_x), 32'(cp.x));
        chk("pix_y", 32'(O_pix_y), 32'(cp.y));
        chk("sof", 32'(O_sof), 32'(cp.sof));
        chk("eol", 32'(O_eol), 32'(cp.eol));
      end else begin
        chk("pix_idle", 32'({O_pix_valid, O_sof, O_eol}), 32'd0);
      end
      while (eof_q.size() > 0 && eof_q[0].cyc < cyc) begin
        chk("eof_missing_at_cycle", 32'(cyc), 32'(eof_q[0].cyc));
        void'(eof_q.pop_front());
      end
      if (eof_q.size() > 0 && eof_q[0].cyc == cyc) begin
        ce = eof_q.pop_front();
        exp_cnt = ce.cnt;
        exp_err = ce.err;
        chk("eof_pulse", 32'(O_eof), 32'd1);
      end else begin
        chk("eof_idle", 32'(O_eof), 32'd0);
      end
      while (act_q.size() > 0 && act_q[0].cyc <= cyc) begin
        ca = act_q.pop_front();
        exp_act = ca.act;
      end
      chk("frame_cnt", 32'(O_frame_cnt), 32'(exp_cnt));
      chk("frame_err", 32'(O_frame_err), 32'(exp_err));
      chk("capture_active", 32'(O_capture_active), 32'(exp_act));
      if (O_pix_valid) log_q.push_back('{cyc, O_pix_data, O_pix_x, O_pix_y, O_sof, O_eol});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic vs, input logic hs, input logic [7:0] d);
    I_vsync = vs; I_href = hs; I_data = d; I_cfg_done = cfg_lvl;
    put_cyc = cyc;
    @(posedge cmos_pclk);
    cyc++;
    #1;
  endtask

  task automatic model_clear();
    pix_q.delete(); eof_q.delete(); act_q.delete(); log_q.delete(); lo_put_q.delete();
    m_mode = M_WAIT; m_skips = 0; m_y = 0; m_cnt = 16'd0; m_err = 1'b0;
    exp_cnt = 16'd0; exp_err = 1'b0; exp_act = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    I_rst_n = 1'b0;
    cfg_lvl = 1'b0;
    model_clear();
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    I_rst_n = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
  endtask

  task automatic set_cfg(input logic v);
    cfg_lvl = v;
    tick(1'b0, 1'b0, 8'h00);
    if (!v) begin
      if (m_mode == M_CAP) act_q.push_back('{cyc, 1'b0});
      m_mode = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      m_mode = M_SKIP;
      m_skips = 0;
    end
  endtask

  // A vsync rise becomes visible to the capture logic one edge after it is sampled.
  task automatic vsync_pulse();
    tick(1'b1, 1'b0, 8'h00);
    if (m_mode == M_SKIP) begin
      if (m_skips == SKIP_FRAMES) begin
        m_mode = M_CAP; m_y = 0; m_err = 1'b0;
        act_q.push_back('{cyc + 1, 1'b1});
      end else begin
        m_skips++;
      end
    end else if (m_mode == M_CAP) begin
      m_cnt++;
      eof_q.push_back('{cyc + 1, m_cnt, m_err | (m_y != V_RES)});
      m_y = 0; m_err = 1'b0;
    end
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    repeat (3) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill_rand(input int n);
    for (int b = 0; b < n; b++) line_buf[b] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_line(input int n, input bit tail);
    int npix;
    for (int b = 0; b < n; b++) begin
      tick(1'b0, 1'b1, line_buf[b]);
      if (m_mode == M_CAP) begin
        if (m_y == V_RES) m_err = 1'b1;
        else if (b % 2 == 1) begin
          if (b / 2 < H_RES) begin
            pix_q.push_back('{cyc + 1, {line_buf[b-1], line_buf[b]}, 12'(b / 2), 12'(m_y),
                              (b / 2 == 0) && (m_y == 0), (b / 2 == H_RES - 1)});
            lo_put_q.push_back(put_cyc);
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
    if (tail) begin
      repeat (3) tick(1'b0, 1'b0, 8'h00);
      if (m_mode == M_CAP && n > 0 && m_y != V_RES) begin
        npix = (n / 2 < H_RES) ? n / 2 : H_RES;
        if (n % 2 == 1 || npix != H_RES) m_err = 1'b1;
        if (npix > 0) m_y++;
      end
    end
  endtask

  task automatic frame(input int nlines, input int nbytes);
    for (int l = 0; l < nlines; l++) begin
      fill_rand(nbytes);
      send_line(nbytes, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // startup skip: partial frame then SKIP_FRAMES+1 rises before capture
    do_reset();
    chk("rst_dbg_state", 32'(dbg_state), 32'd0);
    chk("rst_frame_cnt", 32'(O_frame_cnt), 32'd0);
    set_cfg(1'b1);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    frame(2, 8); vsync_pulse();
    frame(2, 8); vsync_pulse();
    frame(2, 8); vsync_pulse();
    chk("skip_no_valid", 32'(log_q.size()), 32'd0);
    frame(2, 8); vsync_pulse();
    chk("s1_valid_count", 32'(log_q.size()), 32'd8);
    tmp_n = 0;
    for (int i = 0; i < log_q.size(); i++) tmp_n += int'(log_q[i].eol);
    chk("s1_eol_count", 32'(tmp_n), 32'd2);
    if (log_q.size() > 0) chk("s1_first_sof", 32'(log_q[0].sof), 32'd1);
    chk("s1_frame_cnt", 32'(O_frame_cnt), 32'd1);
    chk("s1_frame_err", 32'(O_frame_err), 32'd0);

    // pixel assembly and latency
    log_q.delete(); lo_put_q.delete();
    fill_rand(8);
    line_buf[0] = 8'hF8; line_buf[1] = 8'h00; line_buf[2] = 8'h07; line_buf[3] = 8'hE0;
    send_line(8, 1'b1);
    frame(1, 8); vsync_pulse();
    if (log_q.size() >= 2 && lo_put_q.size() >= 2) begin
      chk("asm_pix0", 32'(log_q[0].data), 32'h0000F800);
      chk("asm_pix0_x", 32'(log_q[0].x), 32'd0);
      chk("asm_pix1", 32'(log_q[1].data), 32'h000007E0);
      chk("asm_pix1_x", 32'(log_q[1].x), 32'd1);
      chk("asm_lat0", 32'(log_q[0].cyc - lo_put_q[0]), 32'd2);
      chk("asm_lat1", 32'(log_q[1].cyc - lo_put_q[1]), 32'd2);
    end else begin
      chk("asm_log_size", 32'(log_q.size()), 32'd8);
    end
    chk("s2_frame_cnt", 32'(O_frame_cnt), 32'd2);

    // short/odd line, then a clean frame
    log_q.delete(); lo_put_q.delete();
    fill_rand(7); send_line(7, 1'b1);
    frame(1, 8); vsync_pulse();
    chk("odd_valid_count", 32'(log_q.size()), 32'd7);
    if (log_q.size() > 3) chk("odd_next_line_y", 32'(log_q[3].y), 32'd1);
    chk("odd_frame_err", 32'(O_frame_err), 32'd1);
    chk("odd_frame_cnt", 32'(O_frame_cnt), 32'd3);
    frame(2, 8); vsync_pulse();
    chk("clean_frame_err", 32'(O_frame_err), 32'd0);

    // overflow in x and y
    log_q.delete(); lo_put_q.delete();
    frame(3, 12); vsync_pulse();
    chk("ovf_valid_count", 32'(log_q.size()), 32'd8);
    tmp_max = 0;
    for (int i = 0; i < log_q.size(); i++) if (int'(log_q[i].x) > tmp_max) tmp_max = int'(log_q[i].x);
    chk("ovf_max_x", 32'(tmp_max), 32'd3);
    chk("ovf_frame_err_1", 32'(O_frame_err), 32'd1);
    frame(3, 12); vsync_pulse();
    chk("ovf_frame_err_2", 32'(O_frame_err), 32'd1);
    chk("ovf_frame_cnt", 32'(O_frame_cnt), 32'd6);

    // config drop after pixel (1,0), then restart of the skip sequence
    log_q.delete(); lo_put_q.delete();
    fill_rand(4); send_line(4, 1'b1);
    set_cfg(1'b0);
    frame(1, 8); vsync_pulse();
    chk("cfgdrop_valid_count", 32'(log_q.size()), 32'd2);
    chk("cfgdrop_frame_cnt", 32'(O_frame_cnt), 32'd6);
    chk("cfgdrop_active", 32'(O_capture_active), 32'd0);
    set_cfg(1'b1);
    vsync_pulse(); frame(1, 8);
    vsync_pulse(); frame(1, 8);
    chk("reskip_active_lo", 32'(O_capture_active), 32'd0);
    vsync_pulse();
    chk("reskip_active_hi", 32'(O_capture_active), 32'd1);
    frame(2, 8); vsync_pulse();
    chk("reskip_frame_cnt", 32'(O_frame_cnt), 32'd7);

    // async reset mid-line
    fill_rand(5); send_line(5, 1'b0);
    #1;
    chk_en = 1'b0;
    I_rst_n = 1'b0;
    #1;
    chk("arst_outputs", 32'({O_pix_valid, O_sof, O_eol, O_eof, O_frame_err, O_capture_active}), 32'd0);
    chk("arst_pix_data", 32'(O_pix_data), 32'd0);
    chk("arst_pix_xy", 32'({O_pix_x, O_pix_y}), 32'd0);
    chk("arst_frame_cnt", 32'(O_frame_cnt), 32'd0);
    chk("arst_dbg_state", 32'(dbg_state), 32'd0);
    do_reset();
    set_cfg(1'b1);
    vsync_pulse(); frame(1, 8);
    chk("arst_skip_active_1", 32'(O_capture_active), 32'd0);
    vsync_pulse(); frame(1, 8);
    chk("arst_skip_active_2", 32'(O_capture_active), 32'd0);
    vsync_pulse();
    chk("arst_capture_active", 32'(O_capture_active), 32'd1);

    // randomized frames
    repeat (10) begin
      tmp_n = $urandom_range(1, 3);
      for (int l = 0; l < tmp_n; l++) begin
        int n;
        n = ($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 13);
        fill_rand(n);
        send_line(n, 1'b1);
      end
      vsync_pulse();
    end

    repeat (4) tick(1'b0, 1'b0, 8'h00);
    chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
    chk("eof_q_drained", 32'(eof_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
